pattern_serializer: RTL



---
 rtl/pattern_serializer_if.sv | 29 ++
 rtl/pattern_serializer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pattern_serializer_if.sv
// Load handshake bundle for pattern_serializer: pattern, length and repeat count
// offered under valid/ready.
interface pattern_serializer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned REP_W = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_pattern;
    logic [LEN_W-1:0] load_len;
    logic [REP_W-1:0] load_rep;

    modport master (
        output load_valid,
        output load_pattern,
        output load_len,
        output load_rep,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_pattern,
        input  load_len,
        input  load_rep,
        output load_ready
    );
endinterface

// File: rtl/pattern_serializer.sv
// Serial pattern generator: sends a captured pattern MSB-first for load_rep+1 passes.
// Define PATTERN_SERIALIZER_GAP_EN to insert one idle cycle between passes.
module pattern_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned REP_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pattern_serializer_if.slave  ld,
    input  logic                 abort,
    output logic                 data_out,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
`ifdef PATTERN_SERIALIZER_GAP_EN
        StGap   = 2'd2,
`endif
        StDone  = 2'd3
    } state_e;

    localparam logic [LEN_W-1:0] WidthL = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);
    localparam logic [REP_W-1:0] RepOne = REP_W'(1);

    state_e           state_q;
    logic [WIDTH-1:0] pattern_q;
    logic [LEN_W-1:0] len_m1_q;
    logic [LEN_W-1:0] idx_q;
    logic [REP_W-1:0] pass_q;
    logic [LEN_W-1:0] cap_len_m1;

    // Zero or oversize lengths mean a full-width pattern.
    always_comb begin
        cap_len_m1 = ld.load_len - LenOne;
        if (ld.load_len == '0 || ld.load_len > WidthL) begin
            cap_len_m1 = WidthL - LenOne;
        end
    end

    function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
        logic [WIDTH-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pattern_q     <= '0;
            len_m1_q      <= '0;
            idx_q         <= '0;
            pass_q        <= '0;
            ld.load_ready <= 1'b1;
            data_out      <= 1'b0;
            data_valid    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else if (abort && state_q != StIdle) begin
            state_q       <= StIdle;
            pattern_q     <= '0;
            len_m1_q      <= '0;
            idx_q         <= '0;
            pass_q        <= '0;
            ld.load_ready <= 1'b1;
            data_out      <= 1'b0;
            data_valid    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ld.load_valid) begin
                        state_q       <= StShift;
                        pattern_q     <= ld.load_pattern;
                        len_m1_q      <= cap_len_m1;
                        idx_q         <= cap_len_m1;
                        pass_q        <= ld.load_rep;
                        ld.load_ready <= 1'b0;
                        busy          <= 1'b1;
                        data_valid    <= 1'b1;
                        data_out      <= bit_at(ld.load_pattern, cap_len_m1);
                    end
                end
                StShift: begin
                    if (idx_q == '0) begin
                        if (pass_q != '0) begin
                            pass_q <= pass_q - RepOne;
                            idx_q  <= len_m1_q;
`ifdef PATTERN_SERIALIZER_GAP_EN
                            state_q    <= StGap;
                            data_valid <= 1'b0;
                            data_out   <= 1'b0;
`else
                            data_out <= bit_at(pattern_q, len_m1_q);
`endif
                        end else begin
                            state_q    <= StDone;
                            data_valid <= 1'b0;
                            data_out   <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end else begin
                        idx_q    <= idx_q - LenOne;
                        data_out <= bit_at(pattern_q, idx_q - LenOne);
                    end
                end
`ifdef PATTERN_SERIALIZER_GAP_EN
                StGap: begin
                    state_q    <= StShift;
                    data_valid <= 1'b1;
                    data_out   <= bit_at(pattern_q, idx_q);
                end
`endif
                StDone: begin
                    state_q       <= StIdle;
                    done          <= 1'b0;
                    ld.load_ready <= 1'b1;
                end
                default: begin
                    state_q       <= StIdle;
                    ld.load_ready <= 1'b1;
                    data_valid    <= 1'b0;
                    data_out      <= 1'b0;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                end
            endcase
        end
    end

endmodule
